// File: rtl/retention_sequencer.sv
// Power-down/power-up sequencer for one retention domain: clock gate, save, isolate, switch off, and reverse.
// Optional handshake timeout on the power switch is built when RETN_SEQ_TIMEOUT_EN is defined.
module retention_sequencer #(
    parameter int SAVE_CYCLES    = 2,
    parameter int ISO_SETUP      = 2,
    parameter int RESTORE_CYCLES = 2,
    parameter int TIMEOUT        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       pwr_good,
    output logic       clk_en,
    output logic       save,
    output logic       restore,
    output logic       iso_en,
    output logic       pwr_off_req,
    output logic       sleep_ack,
    output logic       busy,
    output logic       err,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] S_RUN      = 4'd0;
    localparam logic [3:0] S_STOP_CLK = 4'd1;
    localparam logic [3:0] S_SAVE     = 4'd2;
    localparam logic [3:0] S_ISO      = 4'd3;
    localparam logic [3:0] S_PWR_DN   = 4'd4;
    localparam logic [3:0] S_OFF      = 4'd5;
    localparam logic [3:0] S_PWR_UP   = 4'd6;
    localparam logic [3:0] S_RESTORE  = 4'd7;
    localparam logic [3:0] S_ISO_REL  = 4'd8;

    localparam int MAX_SI  = (SAVE_CYCLES > ISO_SETUP) ? SAVE_CYCLES : ISO_SETUP;
    localparam int MAX_SIR = (MAX_SI > RESTORE_CYCLES) ? MAX_SI : RESTORE_CYCLES;
    localparam int MAX_ALL = (MAX_SIR > TIMEOUT) ? MAX_SIR : TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] SAVE_LAST    = CW'(SAVE_CYCLES - 1);
    localparam logic [CW-1:0] ISO_LAST     = CW'(ISO_SETUP - 1);
    localparam logic [CW-1:0] RESTORE_LAST = CW'(RESTORE_CYCLES - 1);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_cnt_run;
    logic          r_sleep;
    logic          r_wake;
    logic          r_pwr_good;
    logic          r_wake_pend;
    logic          w_wake_pend_next;
    logic          w_down_phase;
    logic          r_clk_en;
    logic          r_save;
    logic          r_restore;
    logic          r_iso_en;
    logic          r_pwr_off_req;
    logic          r_sleep_ack;
    logic          r_busy;

`ifdef RETN_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic w_timeout;
    logic r_err;
`endif

    // Handshake: requests and pwr_good are registered once; every decision uses the registered copies.
    always_comb begin
        w_next = r_state;
`ifdef RETN_SEQ_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            S_RUN:      if (r_sleep && !r_wake) w_next = S_STOP_CLK;
            S_STOP_CLK: w_next = S_SAVE;
            S_SAVE:     if (r_cnt == SAVE_LAST) w_next = S_ISO;
            S_ISO:      if (r_cnt == ISO_LAST) w_next = S_PWR_DN;
            S_PWR_DN: begin
                if (!r_pwr_good) begin
                    w_next = S_OFF;
                end
`ifdef RETN_SEQ_TIMEOUT_EN
                else if (r_cnt == TO_LAST) begin
                    w_next    = S_PWR_UP;
                    w_timeout = 1'b1;
                end
`endif
            end
            S_OFF:      if (r_wake || r_wake_pend) w_next = S_PWR_UP;
            S_PWR_UP: begin
                if (r_pwr_good) begin
                    w_next = S_RESTORE;
                end
`ifdef RETN_SEQ_TIMEOUT_EN
                else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                end
`endif
            end
            S_RESTORE:  if (r_cnt == RESTORE_LAST) w_next = S_ISO_REL;
            S_ISO_REL:  w_next = S_RUN;
            default:    w_next = S_RUN;
        endcase
    end

`ifdef RETN_SEQ_TIMEOUT_EN
    assign w_cnt_run = (r_state == S_SAVE) || (r_state == S_ISO) || (r_state == S_RESTORE) ||
                       (r_state == S_PWR_DN) || (r_state == S_PWR_UP);
`else
    assign w_cnt_run = (r_state == S_SAVE) || (r_state == S_ISO) || (r_state == S_RESTORE);
`endif

    // Counter restarts on every state change and saturates so a long wait cannot wrap.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            w_cnt_next = '0;
        end else if (w_cnt_run && (r_cnt != {CW{1'b1}})) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    assign w_down_phase = (r_state == S_STOP_CLK) || (r_state == S_SAVE) ||
                          (r_state == S_ISO) || (r_state == S_PWR_DN);

    always_comb begin
        w_wake_pend_next = r_wake_pend;
        if ((w_next == S_PWR_UP) && (r_state != S_PWR_UP)) begin
            w_wake_pend_next = 1'b0;
        end else if (r_wake && w_down_phase) begin
            w_wake_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_cnt         <= '0;
            r_sleep       <= 1'b0;
            r_wake        <= 1'b0;
            r_pwr_good    <= 1'b1;
            r_wake_pend   <= 1'b0;
            r_clk_en      <= 1'b1;
            r_save        <= 1'b0;
            r_restore     <= 1'b0;
            r_iso_en      <= 1'b0;
            r_pwr_off_req <= 1'b0;
            r_sleep_ack   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_sleep       <= sleep_req;
            r_wake        <= wake_req;
            r_pwr_good    <= pwr_good;
            r_wake_pend   <= w_wake_pend_next;
            r_clk_en      <= (w_next == S_RUN);
            r_save        <= (w_next == S_SAVE);
            r_restore     <= (w_next == S_RESTORE);
            r_iso_en      <= (w_next == S_ISO) || (w_next == S_PWR_DN) || (w_next == S_OFF) ||
                             (w_next == S_PWR_UP) || (w_next == S_RESTORE);
            r_pwr_off_req <= (w_next == S_PWR_DN) || (w_next == S_OFF);
            r_sleep_ack   <= (w_next == S_OFF);
            r_busy        <= (w_next != S_RUN) && (w_next != S_OFF);
        end
    end

`ifdef RETN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign clk_en      = r_clk_en;
    assign save        = r_save;
    assign restore     = r_restore;
    assign iso_en      = r_iso_en;
    assign pwr_off_req = r_pwr_off_req;
    assign sleep_ack   = r_sleep_ack;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule

// File: doc/retention_sequencer.md
# retention_sequencer

Power-down/power-up sequencer for one switchable domain with retention flops. It produces the save and restore strobes that the domain's retention registers and the retention checker consume. It also drives the domain's clock enable, isolation enable and power-switch request in the mandated order, handshaking with the power switch through `pwr_good`. It sits in the always-on domain, next to the PMU.

## Interface
- `SAVE_CYCLES`, default 2: cycles `save` is held high; minimum 1.
- `ISO_SETUP`, default 2: cycles isolation is held before the power-off request; minimum 1.
- `RESTORE_CYCLES`, default 2: cycles `restore` is held high; minimum 1.
- `TIMEOUT`, default 16: power-switch handshake limit in cycles. Used only with the timeout feature.
- `clk` in 1: always-on clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sleep_req` in 1: level request to power the domain down.
- `wake_req` in 1: request to power the domain up. A single-cycle pulse is sufficient.
- `pwr_good` in 1: power switch status; 1 = domain rail up. Synchronous to `clk`.
- `clk_en` out 1: domain clock enable.
- `save` out 1: retention save strobe.
- `restore` out 1: retention restore strobe.
- `iso_en` out 1: output isolation enable.
- `pwr_off_req` out 1: power switch request; 1 = switch off.
- `sleep_ack` out 1: high only in OFF.
- `busy` out 1: high in any state other than RUN and OFF.
- `err` out 1: sticky handshake timeout flag.

## Operation
- All outputs are registered and decoded from the next-state value, so each output changes on the clock edge that enters a state.
- Reset values: `clk_en`=1; `save`, `restore`, `iso_en`, `pwr_off_req`, `sleep_ack`, `busy`, `err`=0. State = RUN.
- States and outputs:
  - RUN: `clk_en`=1.
  - STOP_CLK: `clk_en`=0.
  - SAVE: `save`=1.
  - ISO: `iso_en`=1.
  - PWR_DN: `iso_en`=1, `pwr_off_req`=1.
  - OFF: `iso_en`=1, `pwr_off_req`=1, `sleep_ack`=1.
  - PWR_UP: `iso_en`=1, `pwr_off_req`=0.
  - RESTORE: `iso_en`=1, `restore`=1.
  - ISO_REL: `iso_en`=0, `clk_en`=0.
  - Back to RUN: `clk_en`=1.
  - `clk_en` is 0 in every state from STOP_CLK through ISO_REL.
- Transitions:
  - RUN → STOP_CLK when `sleep_req`=1 and `wake_req`=0.
  - STOP_CLK → SAVE after 1 cycle.
  - SAVE → ISO after `SAVE_CYCLES`.
  - ISO → PWR_DN after `ISO_SETUP`.
  - PWR_DN → OFF when `pwr_good` is sampled 0.
  - OFF → PWR_UP when `wake_req` or `wake_pend` is 1.
  - PWR_UP → RESTORE when `pwr_good` is sampled 1.
  - RESTORE → ISO_REL after `RESTORE_CYCLES`.
  - ISO_REL → RUN after 1 cycle.
- Wake while powering down: `sleep_req` is sampled only in RUN; a down sequence, once started, always completes. A `wake_req` seen in STOP_CLK through PWR_DN sets `wake_pend`. OFF is then entered for exactly 1 cycle and exits. `wake_pend` clears on entry to PWR_UP.
- Simultaneous requests: in RUN, `wake_req` has priority; no sequence starts. In OFF, `wake_req` wins regardless of `sleep_req`.
- Sleep held high after wake: if `sleep_req` is still 1 on return to RUN, a new down sequence starts on the next edge.
- Cycle counter: a single counter of width `$clog2(max(SAVE_CYCLES, ISO_SETUP, RESTORE_CYCLES, TIMEOUT)+1)`, cleared on every state change.
- Reset mid-sequence: all outputs return to their reset values asynchronously, so the domain is re-powered with `clk_en`=1. This is intentional; the PMU owns reset of the domain.

## Timing
- Down latency, with `sleep_req` sampled at edge 0 and `pwr_good` falling in the first PWR_DN cycle:
  - STOP_CLK at edge 1.
  - SAVE at edge 2.
  - ISO at edge 2+`SAVE_CYCLES`.
  - PWR_DN at edge 2+`SAVE_CYCLES`+`ISO_SETUP`.
  - OFF one edge after `pwr_good`=0 is sampled.
- Up latency, with `wake_req` sampled at edge 0:
  - PWR_UP at edge 1.
  - RESTORE one edge after `pwr_good`=1 is sampled.
  - ISO_REL `RESTORE_CYCLES` later.
  - RUN 1 cycle after that.
- `save` and `restore` are never high together. `save` never overlaps `iso_en`, and `restore` is high only while `iso_en`=1.

## Configuration
- `RETN_SEQ_TIMEOUT_EN` defined: the counter runs in PWR_DN and PWR_UP.
  - PWR_DN: if `pwr_good` is still 1 after `TIMEOUT` cycles, set `err` and go to PWR_UP (power-down aborted; restore still runs).
  - PWR_UP: if `pwr_good` is still 0 after `TIMEOUT` cycles, set `err` and keep waiting.
  - `err` clears only on reset.
- `RETN_SEQ_TIMEOUT_EN` undefined: handshake waits are unbounded, and `err` is tied to 0.

## Test plan
- Nominal cycle with defaults: `sleep_req`=1, then `pwr_good` drops 1 cycle after `pwr_off_req` → `clk_en` 0 at edge 1, `save` high edges 2–3, `iso_en` from edge 4, `pwr_off_req` at edge 6, `sleep_ack` at edge 8. Then `wake_req`, with `pwr_good` returning after 3 cycles → `restore` high for 2 cycles, then `iso_en` 0, then `clk_en` 1.
- Wake pulse during SAVE → sequence completes, OFF lasts exactly 1 cycle, PWR_UP follows; `sleep_ack` pulses for 1 cycle.
- `sleep_req` and `wake_req` both high in RUN → no state change, `busy` stays 0. Drop `wake_req` → STOP_CLK on the next edge.
- `rst_n` asserted in PWR_DN → outputs immediately `clk_en`=1, `iso_en`=0, `pwr_off_req`=0; RUN after release.
- With `RETN_SEQ_TIMEOUT_EN`, `pwr_good` stuck at 1 → `err`=1 after 16 cycles in PWR_DN, then PWR_UP → RESTORE → RUN. `err` stays 1.
- With `RETN_SEQ_TIMEOUT_EN`, `pwr_good` stuck at 0 after wake → `err`=1 after 16 cycles in PWR_UP, `restore` stays 0 until `pwr_good` rises.
